// File: rtl/enc_cnt_array.sv
// enc_cnt_array: N-channel encoder A-edge counter, window set by a selected Z.
// Define ENC_PERIOD_EN to add the per-window CLK-cycle period output O_PERIOD.
module enc_cnt_array #(
  parameter int N_CH        = 2,
  parameter int CNT_W       = 64,
  parameter int SYNC_STAGES = 2,
  parameter int SEL_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  CLK,
  input  logic                  I_RSTN,
  input  logic                  I_ARM,
  input  logic [SEL_W-1:0]      I_SEL,
  input  logic [N_CH-1:0]       I_A,
  input  logic [N_CH-1:0]       I_Z,
  output logic [N_CH-1:0]       O_A,
  output logic [N_CH-1:0]       O_Z,
  output logic                  O_ARM,
  output logic [SEL_W-1:0]      O_SEL,
`ifdef ENC_PERIOD_EN
  output logic [N_CH*CNT_W-1:0] O_PERIOD,
`endif
  output logic [N_CH*CNT_W-1:0] O_CNT,
  output logic [N_CH-1:0]       O_READY,
  output logic [N_CH-1:0]       O_OVERFLOW
);

  localparam int IN_W = 2 * N_CH + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_Z,
    COUNT
  } st_e;

  logic [SYNC_STAGES-1:0][IN_W-1:0] sync_q, sync_d;
  logic [IN_W-1:0] prev_q, prev_d;
  logic [IN_W-1:0] in_s, rise;

  logic [N_CH-1:0] a_rise, z_rise;
  logic            arm_rise, arm_lvl, z_ref;

  st_e st_q [N_CH];
  st_e st_d [N_CH];

  logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0][CNT_W-1:0] out_q, out_d;
  logic [N_CH-1:0][CNT_W-1:0] inc;
  logic [N_CH-1:0]            at_max;
  logic [N_CH-1:0]            rdy_q, rdy_d;
  logic [N_CH-1:0]            ovf_q, ovf_d;

`ifdef ENC_PERIOD_EN
  logic [N_CH-1:0][CNT_W-1:0] per_q, per_d;
  logic [N_CH-1:0][CNT_W-1:0] pout_q, pout_d;
  logic [N_CH-1:0][CNT_W-1:0] pinc;
`endif

  assign O_A   = I_A;
  assign O_Z   = I_Z;
  assign O_ARM = I_ARM;
  assign O_SEL = I_SEL;

  always_comb begin
    sync_d[0] = {I_ARM, I_Z, I_A};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign in_s   = sync_q[SYNC_STAGES-1];
  assign prev_d = in_s;
  assign rise   = in_s & ~prev_q;

  assign a_rise   = rise[N_CH-1:0];
  assign z_rise   = rise[2*N_CH-1:N_CH];
  assign arm_rise = rise[IN_W-1];
  assign arm_lvl  = in_s[IN_W-1];

  // Out-of-range select yields no reference edge, so no windows.
  always_comb begin
    z_ref = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (int'(I_SEL) == k) begin
        z_ref = z_rise[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      at_max[k] = (cnt_q[k] == CNT_MAX);
      inc[k]    = (a_rise[k] && !at_max[k]) ?
                  cnt_q[k] + CNT_ONE : cnt_q[k];
`ifdef ENC_PERIOD_EN
      pinc[k]   = (per_q[k] == CNT_MAX) ?
                  per_q[k] : per_q[k] + CNT_ONE;
`endif
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    out_d = out_q;
    ovf_d = ovf_q;
    rdy_d = '0;
`ifdef ENC_PERIOD_EN
    per_d  = per_q;
    pout_d = pout_q;
`endif
    for (int k = 0; k < N_CH; k++) begin
      if (!arm_lvl) begin
        st_d[k]  = IDLE;
        cnt_d[k] = '0;
`ifdef ENC_PERIOD_EN
        per_d[k] = '0;
`endif
      end else begin
        unique case (st_q[k])
          IDLE: begin
            if (arm_rise) begin
              st_d[k]  = WAIT_Z;
              cnt_d[k] = '0;
              ovf_d[k] = 1'b0;
`ifdef ENC_PERIOD_EN
              per_d[k] = '0;
`endif
            end
          end
          WAIT_Z: begin
            if (z_ref) begin
              st_d[k]  = COUNT;
              cnt_d[k] = CNT_W'(a_rise[k]);
`ifdef ENC_PERIOD_EN
              per_d[k] = '0;
`endif
            end
          end
          COUNT: begin
            if (a_rise[k] && at_max[k]) begin
              ovf_d[k] = 1'b1;
            end
            // Closing edge reports and reopens in the same cycle.
            if (z_ref) begin
              out_d[k] = inc[k];
              rdy_d[k] = 1'b1;
              cnt_d[k] = '0;
`ifdef ENC_PERIOD_EN
              pout_d[k] = pinc[k];
              per_d[k]  = '0;
`endif
            end else begin
              cnt_d[k] = inc[k];
`ifdef ENC_PERIOD_EN
              per_d[k] = pinc[k];
`endif
            end
          end
          default: st_d[k] = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      sync_q <= '0;
      prev_q <= '0;
      st_q   <= '{default: IDLE};
      cnt_q  <= '0;
      out_q  <= '0;
      rdy_q  <= '0;
      ovf_q  <= '0;
`ifdef ENC_PERIOD_EN
      per_q  <= '0;
      pout_q <= '0;
`endif
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rdy_q  <= rdy_d;
      ovf_q  <= ovf_d;
`ifdef ENC_PERIOD_EN
      per_q  <= per_d;
      pout_q <= pout_d;
`endif
    end
  end

  assign O_CNT      = out_q;
  assign O_READY    = rdy_q;
  assign O_OVERFLOW = ovf_q;
`ifdef ENC_PERIOD_EN
  assign O_PERIOD   = pout_q;
`endif

endmodule

// File: tb/tb_enc_cnt_array.sv
// tb_enc_cnt_array: directed + random stimulus, window-level reference model,
// expected reports queued and checked by an independent monitor.
module tb_enc_cnt_array;

  logic        CLK = 1'b0;
  logic        I_RSTN;
  logic        I_ARM;
  logic [0:0]  I_SEL;
  logic [1:0]  I_A, I_Z;
  logic [1:0]  O_A, O_Z;
  logic        O_ARM;
  logic [0:0]  O_SEL;
  logic [15:0] O_CNT;
  logic [1:0]  O_READY, O_OVERFLOW;
`ifdef ENC_PERIOD_EN
  logic [15:0] O_PERIOD;
`endif

  enc_cnt_array #(
    .N_CH(2), .CNT_W(8), .SYNC_STAGES(2)
  ) dut (
    .CLK(CLK), .I_RSTN(I_RSTN), .I_ARM(I_ARM),
    .I_SEL(I_SEL), .I_A(I_A), .I_Z(I_Z),
    .O_A(O_A), .O_Z(O_Z), .O_ARM(O_ARM),
    .O_SEL(O_SEL),
`ifdef ENC_PERIOD_EN
    .O_PERIOD(O_PERIOD),
`endif
    .O_CNT(O_CNT), .O_READY(O_READY),
    .O_OVERFLOW(O_OVERFLOW)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h @cyc %0d",
               nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          due;
    logic [15:0] cnt;
    logic [1:0]  ovf;
    logic [15:0] per;
  } exp_t;

  exp_t q[$];

  // Window-level model: unbounded counts, clipped when reported.
  logic [1:0]  p_a, p_z;
  logic        p_arm;
  bit          m_armed, m_open;
  int          m_cnt[2];
  logic [1:0]  m_ovf;
  int          m_open_c;
  logic [15:0] m_last;

  function automatic int clip(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_reset();
    p_a = 0; p_z = 0; p_arm = 0;
    m_armed = 0; m_open = 0;
    m_cnt[0] = 0; m_cnt[1] = 0;
    m_ovf = 0; m_last = 0; m_open_c = 0;
    q.delete();
  endtask

  task automatic model(input logic [1:0] a,
                       input logic [1:0] z,
                       input logic arm);
    logic [1:0] ar, zr;
    logic armr, zref;
    exp_t e;
    int s;
    ar = a & ~p_a;
    zr = z & ~p_z;
    armr = arm & ~p_arm;
    s = int'(I_SEL);
    zref = (s < 2) ? zr[s] : 1'b0;
    if (!arm) begin
      m_armed = 0;
      m_open = 0;
    end else if (armr) begin
      m_armed = 1;
      m_open = 0;
      m_ovf = 0;
    end else if (m_armed) begin
      if (!m_open) begin
        if (zref) begin
          m_open = 1;
          m_open_c = cyc;
          for (int k = 0; k < 2; k++) m_cnt[k] = int'(ar[k]);
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          m_cnt[k] += int'(ar[k]);
          if (m_cnt[k] > 255) m_ovf[k] = 1;
        end
        if (zref) begin
          e.due = cyc + 3;
          e.cnt = {8'(clip(m_cnt[1])), 8'(clip(m_cnt[0]))};
          e.ovf = m_ovf;
          e.per = {2{8'(clip(cyc - m_open_c))}};
          q.push_back(e);
          m_last = e.cnt;
          m_cnt[0] = 0;
          m_cnt[1] = 0;
          m_open_c = cyc;
        end
      end
    end
    p_a = a; p_z = z; p_arm = arm;
  endtask

  task automatic step(input logic [1:0] a,
                      input logic [1:0] z,
                      input logic arm);
    @(negedge CLK);
    I_A = a; I_Z = z; I_ARM = arm;
    model(a, z, arm);
  endtask

  task automatic pulse(input logic [1:0] a,
                       input logic [1:0] z);
    step(a, z, 1'b1);
    step(2'b00, 2'b00, 1'b1);
  endtask

  task automatic idle(input int n, input logic arm);
    for (int i = 0; i < n; i++) step(2'b00, 2'b00, arm);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    I_RSTN = 0; I_A = 0; I_Z = 0; I_ARM = 0;
    #1;
    chk("rst_cnt", 64'(O_CNT), 0);
    chk("rst_ready", 64'(O_READY), 0);
    chk("rst_ovf", 64'(O_OVERFLOW), 0);
`ifdef ENC_PERIOD_EN
    chk("rst_period", 64'(O_PERIOD), 0);
`endif
    model_reset();
    repeat (3) @(negedge CLK);
    I_RSTN = 1;
  endtask

  // Monitor: every O_READY must match the queue head on its due cycle.
  always @(negedge CLK) begin
    exp_t e;
    if (I_RSTN === 1'b1) begin
      while (q.size() > 0 && q[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL ready_missing due=%0d now=%0d got=0",
                 q[0].due, cyc);
        void'(q.pop_front());
      end
      if (O_READY !== 2'b00) begin
        if (q.size() == 0 || q[0].due != cyc) begin
          checks++;
          errors++;
          $display("FAIL ready_unexpected got=%b want=00 @cyc %0d",
                   O_READY, cyc);
        end else begin
          e = q.pop_front();
          chk("ready", 64'(O_READY), 64'(2'b11));
          chk("cnt0", 64'(O_CNT[7:0]), 64'(e.cnt[7:0]));
          chk("cnt1", 64'(O_CNT[15:8]), 64'(e.cnt[15:8]));
          chk("ovf", 64'(O_OVERFLOW), 64'(e.ovf));
`ifdef ENC_PERIOD_EN
          chk("period", 64'(O_PERIOD), 64'(e.per));
`endif
        end
      end
    end
  end

  int len;
  logic [1:0] ra, rz;

  initial begin
    I_RSTN = 1; I_ARM = 0; I_SEL = 0; I_A = 0; I_Z = 0;
    model_reset();
    do_reset();

    // Basic window: 5 A0 and 3 A1 edges.
    idle(4, 1);
    pulse(2'b00, 2'b01);
    for (int i = 0; i < 5; i++) pulse({i < 3, 1'b1}, 2'b00);
    pulse(2'b00, 2'b01);
    idle(6, 1);
    #1;
    chk("pass", 64'({O_A, O_Z, O_ARM, O_SEL}),
        64'({I_A, I_Z, I_ARM, I_SEL}));

    // Saturation, sticky overflow, cleared by re-arm.
    for (int i = 0; i < 300; i++) pulse(2'b01, 2'b00);
    pulse(2'b00, 2'b01);
    pulse(2'b01, 2'b00);
    pulse(2'b01, 2'b00);
    pulse(2'b00, 2'b01);
    idle(6, 0);
    idle(4, 1);
    pulse(2'b00, 2'b01);
    pulse(2'b01, 2'b00);
    pulse(2'b00, 2'b01);

    // Coincident A and closing Z, then empty window.
    for (int i = 0; i < 4; i++) pulse(2'b01, 2'b00);
    pulse(2'b01, 2'b01);
    idle(2, 1);
    pulse(2'b00, 2'b01);

    // Z1 as reference with Z0 noise.
    idle(4, 0);
    I_SEL = 1;
    idle(4, 0);
    idle(4, 1);
    pulse(2'b00, 2'b10);
    for (int i = 0; i < 7; i++) pulse(2'b01, {1'b0, i[0]});
    pulse(2'b00, 2'b10);
    idle(5, 1);

    // Disarm mid-window: O_CNT holds last report.
    for (int i = 0; i < 6; i++) pulse(2'b11, 2'b00);
    idle(8, 0);
    #1;
    chk("hold_cnt", 64'(O_CNT), 64'(m_last));
    I_SEL = 0;
    idle(4, 0);
    idle(4, 1);
    pulse(2'b00, 2'b01);
    for (int i = 0; i < 3; i++) pulse(2'b11, 2'b00);
    do_reset();

    // Randomised arm blocks.
    for (int b = 0; b < 8; b++) begin
      idle(6, 0);
      I_SEL = 1'($urandom_range(0, 1));
      idle(6, 0);
      len = $urandom_range(100, 400);
      for (int i = 0; i < len; i++) begin
        ra = 2'($urandom_range(0, 3));
        rz[0] = ($urandom_range(0, 11) == 0);
        rz[1] = ($urandom_range(0, 11) == 0);
        step(ra, rz, 1'b1);
      end
    end

    idle(10, I_ARM);
    #1;
    chk("queue_empty", 64'(q.size()), 0);
    chk("final_cnt", 64'(O_CNT), 64'(m_last));
    chk("final_ovf", 64'(O_OVERFLOW), 64'(m_ovf));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
